// File: rtl/lcm_para_rom_sequencer.sv
// lcm_para_rom_sequencer
// Fetches a byte-coded command script from ROM and replays it as 8080-style
// write cycles (CS#, DC, WR#, D[7:0]) to an LCD module.
// Record format: control byte {type[7:6], cnt[5:0]}
//   00 CMD   : next byte sent with DC=0
//   01 DATA  : next cnt+1 bytes sent with DC=1
//   10 DELAY : wait (cnt+1)*DELAY_UNIT clocks
//   11 END   : finish
// Optional build macro LCM_HW_RESET_EN: adds lcm_rst_n and pulses the panel
// reset (1 unit low, 5 units recovery) before the first control fetch.
module lcm_para_rom_sequencer #(
  parameter int ADDR_WIDTH  = 10,
  parameter int ROM_LATENCY = 1,
  parameter int START_ADDR  = 0,
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2,
  parameter int DELAY_UNIT  = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_rd_data,
  output logic                  lcm_cs_n,
  output logic                  lcm_dc,
  output logic                  lcm_wr_n,
  output logic                  lcm_rd_n,
  output logic [7:0]            lcm_data
`ifdef LCM_HW_RESET_EN
  ,
  output logic                  lcm_rst_n
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    FETCH_CTRL,
    DECODE,
    FETCH_DATA,
    WR_LOW,
    WR_HIGH,
    DELAY,
    FINISH
`ifdef LCM_HW_RESET_EN
    ,
    HW_RST_LOW,
    HW_RST_WAIT
`endif
  } state_t;

  localparam logic [1:0] T_CMD   = 2'b00;
  localparam logic [1:0] T_DATA  = 2'b01;
  localparam logic [1:0] T_DELAY = 2'b10;

  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
  localparam logic [25:0] LAT_LAST     = 26'(ROM_LATENCY - 1);
  localparam logic [25:0] WR_LOW_LAST  = 26'(WR_LOW_CYC - 1);
  localparam logic [25:0] WR_HIGH_LAST = 26'(WR_HIGH_CYC - 1);
`ifdef LCM_HW_RESET_EN
  localparam logic [25:0] HW_LOW_LAST  = 26'(DELAY_UNIT - 1);
  localparam logic [25:0] HW_WAIT_LAST = 26'(5 * DELAY_UNIT - 1);
`endif

  state_t      state, state_next;
  logic [25:0] cnt_q;        // clocks spent in the current state
  logic [7:0]  ctrl_q;       // control byte of the record being executed
  logic [6:0]  remaining;    // payload bytes still to send for this record
  logic        dc_mode;      // DC level for the payload of this record
  logic        addr_ovf;     // last ROM address has been consumed
  logic        fetch_ready;  // ROM data valid for the held address
  logic [25:0] dly_last;     // final count of a DELAY record

  assign fetch_ready = (cnt_q == LAT_LAST);
  assign dly_last    = 26'((32'(ctrl_q[5:0]) + 32'd1) * 32'(DELAY_UNIT) - 32'd1);

  // State register; reset forces IDLE on the next edge, aborting any WR# low phase.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic for script execution.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef LCM_HW_RESET_EN
          state_next = HW_RST_LOW;
`else
          state_next = FETCH_CTRL;
`endif
        end
      end
      FETCH_CTRL: begin
        if (addr_ovf)         state_next = IDLE;
        else if (fetch_ready) state_next = DECODE;
      end
      DECODE: begin
        case (ctrl_q[7:6])
          T_CMD, T_DATA: state_next = FETCH_DATA;
          T_DELAY:       state_next = DELAY;
          default:       state_next = FINISH;
        endcase
      end
      FETCH_DATA: begin
        if (addr_ovf)         state_next = IDLE;
        else if (fetch_ready) state_next = WR_LOW;
      end
      WR_LOW:  if (cnt_q == WR_LOW_LAST) state_next = WR_HIGH;
      WR_HIGH: begin
        if (cnt_q == WR_HIGH_LAST)
          state_next = (remaining == 7'd1) ? FETCH_CTRL : FETCH_DATA;
      end
      DELAY:   if (cnt_q == dly_last) state_next = FETCH_CTRL;
      FINISH:  state_next = IDLE;
`ifdef LCM_HW_RESET_EN
      HW_RST_LOW:  if (cnt_q == HW_LOW_LAST)  state_next = HW_RST_WAIT;
      HW_RST_WAIT: if (cnt_q == HW_WAIT_LAST) state_next = FETCH_CTRL;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Per-state clock counter shared by fetch latency, WR phases and delays.
  always_ff @(posedge clk) begin
    if (rst || state == IDLE || state_next != state) cnt_q <= '0;
    else                                              cnt_q <= cnt_q + 26'd1;
  end

  // Script datapath: ROM address, fetched bytes, payload count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr  <= ADDR_FIRST;
      addr_ovf  <= 1'b0;
      ctrl_q    <= 8'h00;
      remaining <= 7'd0;
      dc_mode   <= 1'b0;
      lcm_dc    <= 1'b0;
      lcm_data  <= 8'h00;
      err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rom_addr <= ADDR_FIRST;
            addr_ovf <= 1'b0;
            err      <= 1'b0;
          end
        end
        FETCH_CTRL, FETCH_DATA: begin
          if (addr_ovf) begin
            err <= 1'b1;
          end else if (fetch_ready) begin
            if (state == FETCH_CTRL) begin
              ctrl_q <= rom_rd_data;
            end else begin
              // Bus and DC change on the same edge that drops WR#.
              lcm_data <= rom_rd_data;
              lcm_dc   <= dc_mode;
            end
            // The address never wraps; running past the end is flagged instead.
            if (rom_addr == ADDR_LAST) addr_ovf <= 1'b1;
            else                       rom_addr <= rom_addr + ADDR_WIDTH'(1);
          end
        end
        DECODE: begin
          dc_mode   <= (ctrl_q[7:6] == T_DATA);
          remaining <= (ctrl_q[7:6] == T_DATA) ? 7'(ctrl_q[5:0]) + 7'd1 : 7'd1;
        end
        WR_HIGH: if (state_next != WR_HIGH) remaining <= remaining - 7'd1;
        default: ;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    busy     = 1'b1;
    done     = 1'b0;
    lcm_cs_n = 1'b1;
    lcm_wr_n = 1'b1;
    lcm_rd_n = 1'b1;
`ifdef LCM_HW_RESET_EN
    lcm_rst_n = (state != HW_RST_LOW);
`endif
    case (state)
      IDLE:   busy = 1'b0;
      FINISH: begin
        busy = 1'b0;
        done = 1'b1;
      end
      WR_LOW: begin
        lcm_cs_n = 1'b0;
        lcm_wr_n = 1'b0;
      end
      WR_HIGH: lcm_cs_n = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcm_para_rom_sequencer.sv
// tb_lcm_para_rom_sequencer
// Three instances: #0 ROM_LATENCY=1, #1 ROM_LATENCY=2 (registered ROM),
// #2 ADDR_WIDTH=4. DELAY_UNIT=10 everywhere. Expected write bytes and
// timings come from a script walker that applies the record rules directly.
module tb_lcm_para_rom_sequencer;

  localparam int N  = 3;
  localparam int DU = 10;
  localparam int WL = 2;
  localparam int WH = 2;
`ifdef LCM_HW_RESET_EN
  localparam int HW_EXTRA = 6 * DU;
`else
  localparam int HW_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]      start, busy, done, err, cs_n, dc, wr_n, rd_n;
  logic [N-1:0][7:0] data, rd_data;
  logic [N-1:0][9:0] addr;
`ifdef LCM_HW_RESET_EN
  logic [N-1:0]      hw_rst_n;
`endif
  logic [7:0] rom [N][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int AW  = (g == 2) ? 4 : 10;
    localparam int LAT = (g == 1) ? 2 : 1;
    logic [AW-1:0] a;

    lcm_para_rom_sequencer #(
      .ADDR_WIDTH(AW), .ROM_LATENCY(LAT), .START_ADDR(0),
      .WR_LOW_CYC(WL), .WR_HIGH_CYC(WH), .DELAY_UNIT(DU)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]),
      .busy(busy[g]), .done(done[g]), .err(err[g]),
      .rom_addr(a), .rom_rd_data(rd_data[g]),
      .lcm_cs_n(cs_n[g]), .lcm_dc(dc[g]), .lcm_wr_n(wr_n[g]),
      .lcm_rd_n(rd_n[g]),
`ifdef LCM_HW_RESET_EN
      .lcm_rst_n(hw_rst_n[g]),
`endif
      .lcm_data(data[g])
    );

    assign addr[g] = 10'(a);

    if (LAT == 1) begin : g_rom_comb
      assign rd_data[g] = rom[g][addr[g]];
    end else begin : g_rom_reg
      logic [9:0] aq;
      always @(posedge clk) aq <= addr[g];
      assign rd_data[g] = rom[g][aq];
    end
  end

  // ---------------- bus monitor (samples on falling edge) ----------------
  int unsigned tick = 0;
  int          ev_n [N];
  logic [8:0]  ev_val [N][256];
  int unsigned ev_t [N][256];
  int          done_n [N], err_n [N];
  int unsigned done_t [N], err_t [N];
  int          low_run [N], low_bad [N], cs_bad [N];
  logic        wr_prev [N], err_prev [N];

  always @(negedge clk) begin
    tick++;
    for (int g = 0; g < N; g++) begin
      if (wr_n[g] === 1'b0) begin
        low_run[g]++;
        if (cs_n[g] !== 1'b0) cs_bad[g]++;
      end else if (wr_n[g] === 1'b1 && wr_prev[g] === 1'b0) begin
        if (ev_n[g] < 256) begin
          ev_val[g][ev_n[g]] = {dc[g], data[g]};
          ev_t[g][ev_n[g]]   = tick;
        end
        ev_n[g]++;
        if (low_run[g] != WL) low_bad[g]++;
        low_run[g] = 0;
      end
      if (done[g] === 1'b1) begin
        done_n[g]++;
        done_t[g] = tick;
      end
      if (err[g] === 1'b1 && err_prev[g] !== 1'b1) begin
        err_n[g]++;
        err_t[g] = tick;
      end
      wr_prev[g]  = wr_n[g];
      err_prev[g] = err[g];
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, want);
    end
  endtask

  // ---------------- reference model: walk the script ----------------
  int         exp_n, exp_done, exp_err, exp_addr;
  logic [8:0] exp_val [256];
  int         exp_t [256];

  task automatic model(input int g, input int aw, input int lat);
    int         a, k, last, n;
    bit         ovf, fin;
    logic [7:0] b;
    a = 0; k = HW_EXTRA; last = (1 << aw) - 1; ovf = 0; fin = 0;
    exp_n = 0; exp_done = -1; exp_err = -1;
    while (!fin) begin
      if (ovf) begin
        k++;
        exp_err = k + 1;
        fin = 1;
      end else begin
        k += lat;
        b = rom[g][a];
        if (a == last) ovf = 1; else a++;
        k += 1;
        case (b[7:6])
          2'b00, 2'b01: begin
            n = (b[7:6] == 2'b00) ? 1 : int'(b[5:0]) + 1;
            for (int i = 0; i < n; i++) begin
              if (ovf) begin
                k++;
                exp_err = k + 1;
                fin = 1;
                break;
              end
              k += lat;
              exp_val[exp_n] = {b[6], rom[g][a]};
              exp_t[exp_n]   = k + WL + 1;
              exp_n++;
              if (a == last) ovf = 1; else a++;
              k += WL + WH;
            end
          end
          2'b10: k += (int'(b[5:0]) + 1) * DU;
          default: begin
            exp_done = k + 1;
            fin = 1;
          end
        endcase
      end
    end
    exp_addr = a;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_log(input int g);
    ev_n[g] = 0; done_n[g] = 0; err_n[g] = 0; done_t[g] = 0; err_t[g] = 0;
    low_run[g] = 0; low_bad[g] = 0; cs_bad[g] = 0;
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk); #1 start[g] = 1'b1;
    @(posedge clk); #1 start[g] = 1'b0;
  endtask

  task automatic launch(input int g, output int unsigned t0);
    clear_log(g);
    pulse_start(g);
    t0 = tick;
  endtask

  task automatic wait_end(input int g, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done_n[g] != 0 || err_n[g] != 0) begin
        ok = 1;
        break;
      end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_run(input int g, input int unsigned t0, input bit ok, input string tag);
    int m;
    check({tag, ".finished"}, 32'(ok), 32'd1);
    check({tag, ".writes"}, ev_n[g], exp_n);
    m = (ev_n[g] < exp_n) ? ev_n[g] : exp_n;
    if (m > 256) m = 256;
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s.byte%0d", tag, i), 32'(ev_val[g][i]), 32'(exp_val[i]));
      check($sformatf("%s.rise%0d", tag, i), ev_t[g][i] - t0, exp_t[i]);
    end
    check({tag, ".done_cnt"}, done_n[g], (exp_done >= 0) ? 1 : 0);
    if (exp_done >= 0) check({tag, ".done_cyc"}, done_t[g] - t0, exp_done);
    check({tag, ".err_rise"}, err_n[g], (exp_err >= 0) ? 1 : 0);
    if (exp_err >= 0) check({tag, ".err_cyc"}, err_t[g] - t0, exp_err);
    check({tag, ".err"}, 32'(err[g]), (exp_err >= 0) ? 1 : 0);
    check({tag, ".busy"}, 32'(busy[g]), 0);
    check({tag, ".addr"}, 32'(addr[g]), exp_addr);
    check({tag, ".wr_low_width"}, low_bad[g], 0);
    check({tag, ".cs_during_wr"}, cs_bad[g], 0);
  endtask

  task automatic run_check(input int g, input int aw, input int lat, input string tag,
                           input bit poke);
    int unsigned t0;
    bit ok;
    model(g, aw, lat);
    launch(g, t0);
    if (poke) begin
      repeat (2) @(posedge clk);
      pulse_start(g);   // ignored while busy
    end
    wait_end(g, 3000, ok);
    check_run(g, t0, ok, tag);
  endtask

  task automatic gen_script(input int g);
    int p, t, n;
    p = 0;
    for (int i = 0; i < 1024; i++) rom[g][i] = 8'hC0;
    for (int r = 0; r < 6; r++) begin
      t = $urandom_range(0, 2);
      case (t)
        0: begin
          rom[g][p] = 8'h00; rom[g][p+1] = 8'($urandom); p += 2;
        end
        1: begin
          n = $urandom_range(0, 5);
          rom[g][p] = {2'b01, 6'(n)}; p++;
          for (int j = 0; j <= n; j++) begin
            rom[g][p] = 8'($urandom); p++;
          end
        end
        default: begin
          rom[g][p] = {2'b10, 6'($urandom_range(0, 2))}; p++;
        end
      endcase
    end
    rom[g][p] = 8'hC0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned t0;
    bit ok;
    start = '0;
    rst   = 1'b1;
    for (int g = 0; g < N; g++)
      for (int i = 0; i < 1024; i++) rom[g][i] = 8'hC0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst%0d.busy", g), 32'(busy[g]), 0);
      check($sformatf("rst%0d.done", g), 32'(done[g]), 0);
      check($sformatf("rst%0d.err", g), 32'(err[g]), 0);
      check($sformatf("rst%0d.cs_n", g), 32'(cs_n[g]), 1);
      check($sformatf("rst%0d.dc", g), 32'(dc[g]), 0);
      check($sformatf("rst%0d.wr_n", g), 32'(wr_n[g]), 1);
      check($sformatf("rst%0d.rd_n", g), 32'(rd_n[g]), 1);
      check($sformatf("rst%0d.data", g), 32'(data[g]), 0);
      check($sformatf("rst%0d.addr", g), 32'(addr[g]), 0);
`ifdef LCM_HW_RESET_EN
      check($sformatf("rst%0d.lcm_rst_n", g), 32'(hw_rst_n[g]), 1);
`endif
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // CMD only
    rom[0][0] = 8'h00; rom[0][1] = 8'h11; rom[0][2] = 8'hC0;
    run_check(0, 10, 1, "cmd", 1'b0);

    // DATA run: three bytes, one every 5 clocks
    rom[0][0] = 8'h02; rom[0][1] = 8'hAA; rom[0][2] = 8'hBB;
    rom[0][3] = 8'hCC; rom[0][4] = 8'hC0;
    run_check(0, 10, 1, "data", 1'b0);

    // DELAY of 4 units, no writes
    rom[0][0] = 8'h83; rom[0][1] = 8'hC0;
    run_check(0, 10, 1, "delay", 1'b0);

    // Registered ROM, CMD-only script
    rom[1][0] = 8'h00; rom[1][1] = 8'h11; rom[1][2] = 8'hC0;
    run_check(1, 10, 2, "lat2", 1'b0);

    // Address overflow on a 16-byte ROM with no END
    for (int i = 0; i < 16; i += 2) begin
      rom[2][i] = 8'h00; rom[2][i+1] = 8'h55;
    end
    run_check(2, 4, 1, "ovf1", 1'b0);
    model(2, 4, 1);
    launch(2, t0);
    check("ovf2.err_cleared", 32'(err[2]), 0);
    check("ovf2.busy_after_start", 32'(busy[2]), 1);
    wait_end(2, 3000, ok);
    check_run(2, t0, ok, "ovf2");

    // Reset during WR_LOW of a DATA run
    rom[0][0] = 8'h02; rom[0][1] = 8'hAA; rom[0][2] = 8'hBB;
    rom[0][3] = 8'hCC; rom[0][4] = 8'hC0;
    launch(0, t0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (wr_n[0] === 1'b0) begin
        ok = 1;
        break;
      end
    end
    check("abort.reached_wr_low", 32'(ok), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.wr_n", 32'(wr_n[0]), 1);
    check("abort.cs_n", 32'(cs_n[0]), 1);
    check("abort.busy", 32'(busy[0]), 0);
    check("abort.addr", 32'(addr[0]), 0);
    check("abort.data", 32'(data[0]), 0);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort.no_done", done_n[0], 0);
    run_check(0, 10, 1, "replay", 1'b0);

    // Random scripts, with a second start while busy
    for (int r = 0; r < 4; r++) begin
      gen_script(0);
      run_check(0, 10, 1, $sformatf("rnd%0d", r), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
